// File: rtl/rf_wb_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Holds register-file geometry and the queued entry layout.
package rf_wb_queue_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_SELW  = 3;
  localparam int RF_NREGS = 8;

  typedef struct packed {
    logic [RF_SELW-1:0]  sel;
    logic [RF_WIDTH-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/rf_wb_queue_fifo.sv
// wbq_fifo: in-order storage with dual push (0 older, 1 younger) and one pop.
// Ports: clk/rst, push0/1 {sel,data}, pop; exposes count, rd_ptr, raw storage.
module wbq_fifo
  import rf_wb_queue_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int SELW  = RF_SELW,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push0,
  input  logic [SELW-1:0]             sel0,
  input  logic [WIDTH-1:0]            data0,
  input  logic                        push1,
  input  logic [SELW-1:0]             sel1,
  input  logic [WIDTH-1:0]            data1,
  input  logic                        pop,
  output logic [CW-1:0]               count,
  output logic [PW-1:0]               rd_ptr,
  output logic [DEPTH-1:0][SELW-1:0]  mem_sel,
  output logic [DEPTH-1:0][WIDTH-1:0] mem_data
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] wr1_idx;

  assign wr_nxt  = wr_ptr + PW'(1);
  assign wr1_idx = push0 ? wr_nxt : wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push0)
                       + PW'(push1);
      count  <= count + CW'(push0)
                      + CW'(push1)
                      - CW'(pop);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_sel[wr_ptr]  <= sel0;
      mem_data[wr_ptr] <= data0;
    end
    if (push1) begin
      mem_sel[wr1_idx]  <= sel1;
      mem_data[wr1_idx] <= data1;
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: merges ALU (A) and memory (B) write-backs into the RF port.
// Ports: a_*/b_* handshakes, write/writeregsel/writedata, lk1/lk2, err, full, empty.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int SELW  = $clog2(RF_NREGS),
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [SELW-1:0]  a_sel,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [SELW-1:0]  b_sel,
  input  logic [WIDTH-1:0] b_data,
  output logic             write,
  output logic [SELW-1:0]  writeregsel,
  output logic [WIDTH-1:0] writedata,
  input  logic [SELW-1:0]  lk1sel,
  input  logic [SELW-1:0]  lk2sel,
  output logic             lk1hit,
  output logic             lk2hit,
  output logic [WIDTH-1:0] lk1data,
  output logic [WIDTH-1:0] lk2data,
  output logic             err,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]               count;
  logic [PW-1:0]               rd_ptr;
  logic [DEPTH-1:0][SELW-1:0]  mem_sel;
  logic [DEPTH-1:0][WIDTH-1:0] mem_data;
  logic                        a_acc;
  logic                        b_acc;
  logic                        pop;

  wbq_fifo #(
    .WIDTH (WIDTH),
    .SELW  (SELW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push0    (a_acc),
    .sel0     (a_sel),
    .data0    (a_data),
    .push1    (b_acc),
    .sel1     (b_sel),
    .data1    (b_data),
    .pop      (pop),
    .count    (count),
    .rd_ptr   (rd_ptr),
    .mem_sel  (mem_sel),
    .mem_data (mem_data)
  );

  // Space is judged on the start-of-cycle count; a same-cycle
  // drain does not make room.
  always_comb begin
    a_ready = count < CW'(DEPTH);
    b_ready = (count <= CW'(DEPTH - 2))
            || (a_ready && !a_valid);
  end

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop   = !empty;
  assign write = !empty;

  assign writeregsel = write ? mem_sel[rd_ptr]  : '0;
  assign writedata   = write ? mem_data[rd_ptr] : '0;

  // Walk oldest to youngest so later matches override earlier.
  function automatic logic [WIDTH:0] find(
    input logic [SELW-1:0]             s,
    input logic [PW-1:0]               rp,
    input logic [CW-1:0]               cnt,
    input logic [DEPTH-1:0][SELW-1:0]  ms,
    input logic [DEPTH-1:0][WIDTH-1:0] md
  );
    logic             hit;
    logic [WIDTH-1:0] d;
    logic [PW-1:0]    idx;
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if (CW'(i) < cnt && ms[idx] == s) begin
        hit = 1'b1;
        d   = md[idx];
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {lk1hit, lk1data} = find(lk1sel, rd_ptr,
                             count, mem_sel,
                             mem_data);
    {lk2hit, lk2data} = find(lk2sel, rd_ptr,
                             count, mem_sel,
                             mem_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= a_acc && b_acc
          && (a_sel == b_sel);
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: vector table plus
// streaming, reset and pointer-wrap sequences.
module tb_rf_wb_queue;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [2:0]  a_sel, b_sel;
  logic [15:0] a_data, b_data;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [2:0]  lk1sel, lk2sel;
  logic        lk1hit, lk2hit;
  logic [15:0] lk1data, lk2data;
  logic        err, full, empty;

  int total = 0;
  int bad   = 0;

  rf_wb_queue dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_sel       (a_sel),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_sel       (b_sel),
    .b_data      (b_data),
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .lk1sel      (lk1sel),
    .lk2sel      (lk2sel),
    .lk1hit      (lk1hit),
    .lk2hit      (lk2hit),
    .lk1data     (lk1data),
    .lk2data     (lk2data),
    .err         (err),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    a_data  = '0;
    b_data  = '0;
  endtask

  typedef struct {
    logic        av;
    logic [2:0]  as;
    logic [15:0] ad;
    logic        bv;
    logic [2:0]  bs;
    logic [15:0] bd;
    logic [2:0]  l1;
    logic [2:0]  l2;
    logic        wr;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        ar;
    logic        br;
    logic        em;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
    logic        er;
  } vec_t;

  vec_t vt[10];

  initial begin
    int mc, ia, ib, fr;
    logic ear, ebr, na, nb, eerr;
    logic [18:0] sb[$];
    logic [18:0] ex;

    vt[0] = '{1,3,16'h1234,0,0,0,3,0,
              0,0,0,1,1,1,0,0,0,0,0};
    vt[1] = '{0,0,0,0,0,0,3,0,
              1,3,16'h1234,1,1,0,
              1,16'h1234,0,0,0};
    vt[2] = '{0,0,0,0,0,0,3,0,
              0,0,0,1,1,1,0,0,0,0,0};
    vt[3] = '{1,2,16'hAAAA,1,2,16'hBBBB,
              2,0,0,0,0,1,1,1,0,0,0,0,0};
    vt[4] = '{0,0,0,0,0,0,2,0,
              1,2,16'hAAAA,1,1,0,
              1,16'hBBBB,0,0,1};
    vt[5] = '{1,1,16'h0011,1,5,16'h0001,
              2,5,1,2,16'hBBBB,1,1,0,
              1,16'hBBBB,0,0,0};
    vt[6] = '{1,5,16'h0002,0,0,0,0,5,
              1,1,16'h0011,1,1,0,
              0,0,1,16'h0001,0};
    vt[7] = '{0,0,0,0,0,0,1,5,
              1,5,16'h0001,1,1,0,
              0,0,1,16'h0002,0};
    vt[8] = '{0,0,0,0,0,0,5,5,
              1,5,16'h0002,1,1,0,
              1,16'h0002,1,16'h0002,0};
    vt[9] = '{0,0,0,0,0,0,5,5,
              0,0,0,1,1,1,0,0,0,0,0};

    rst    = 1'b0;
    lk1sel = '0;
    lk2sel = '0;
    idle();
    #2;
    chk("rst_write", write, 0);
    chk("rst_wsel", writeregsel, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aready", a_ready, 1);
    chk("rst_bready", b_ready, 1);
    chk("rst_hit", {lk1hit, lk2hit}, 0);
    chk("rst_err", err, 0);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a_valid = vt[i].av;
      a_sel   = vt[i].as;
      a_data  = vt[i].ad;
      b_valid = vt[i].bv;
      b_sel   = vt[i].bs;
      b_data  = vt[i].bd;
      lk1sel  = vt[i].l1;
      lk2sel  = vt[i].l2;
      #1;
      chk($sformatf("v%0d_write", i), write, vt[i].wr);
      chk($sformatf("v%0d_wsel", i), writeregsel, vt[i].ws);
      chk($sformatf("v%0d_wdata", i), writedata, vt[i].wd);
      chk($sformatf("v%0d_aready", i), a_ready, vt[i].ar);
      chk($sformatf("v%0d_bready", i), b_ready, vt[i].br);
      chk($sformatf("v%0d_empty", i), empty, vt[i].em);
      chk($sformatf("v%0d_lk1hit", i), lk1hit, vt[i].h1);
      chk($sformatf("v%0d_lk1data", i), lk1data, vt[i].d1);
      chk($sformatf("v%0d_lk2hit", i), lk2hit, vt[i].h2);
      chk($sformatf("v%0d_lk2data", i), lk2data, vt[i].d2);
      chk($sformatf("v%0d_err", i), err, vt[i].er);
      @(negedge clk);
    end

    // Both producers always valid; scoreboard tracks order.
    idle();
    mc = 0; ia = 0; ib = 0; eerr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      a_valid = 1'b1;
      a_sel   = 3'(ia % 8);
      a_data  = 16'(32'hA000 + ia);
      b_valid = 1'b1;
      b_sel   = 3'((ib + 4) % 8);
      b_data  = 16'(32'hB000 + ib);
      #1;
      fr  = 4 - mc;
      ear = fr >= 1;
      ebr = fr >= 2;
      chk($sformatf("s%0d_aready", c), a_ready, ear);
      chk($sformatf("s%0d_bready", c), b_ready, ebr);
      chk($sformatf("s%0d_full", c), full, mc == 4);
      chk($sformatf("s%0d_empty", c), empty, mc == 0);
      chk($sformatf("s%0d_err", c), err, eerr);
      chk($sformatf("s%0d_write", c), write, mc > 0);
      if (mc > 0) begin
        ex = sb.pop_front();
        chk($sformatf("s%0d_wentry", c),
            {writeregsel, writedata}, ex);
      end
      na = ear;
      nb = ebr;
      if (na) sb.push_back({a_sel, a_data});
      if (nb) sb.push_back({b_sel, b_data});
      eerr = na && nb && (a_sel == b_sel);
      ia += int'(na);
      ib += int'(nb);
      mc = mc + int'(na) + int'(nb) - int'(mc > 0);
      @(negedge clk);
    end

    // Mid-cycle reset with entries queued.
    lk1sel = a_sel;
    idle();
    #1;
    chk("pre_rst_write", write, mc > 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_write", write, 0);
    chk("mid_rst_wsel", writeregsel, 0);
    chk("mid_rst_wdata", writedata, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_hit", lk1hit, 0);
    chk("mid_rst_bready", b_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("post_rst%0d_write", k), write, 0);
      chk($sformatf("post_rst%0d_empty", k), empty, 1);
      @(negedge clk);
    end

    // Single pushes back to back, wrapping the pointers.
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        a_valid = 1'b1;
        a_sel   = 3'(k % 8);
        a_data  = 16'(32'h5000 + k);
      end else begin
        idle();
      end
      #1;
      chk($sformatf("w%0d_write", k), write, k > 0);
      if (k > 0) begin
        chk($sformatf("w%0d_wsel", k),
            writeregsel, (k - 1) % 8);
        chk($sformatf("w%0d_wdata", k),
            writedata, 32'h5000 + k - 1);
      end
      chk($sformatf("w%0d_aready", k), a_ready, 1);
      @(negedge clk);
    end
    #1;
    chk("wrap_empty", empty, 1);
    chk("wrap_write", write, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
